// File: rtl/video_timing_pkg.sv
// Shared constants and types for the raster timing generator.
package video_timing_pkg;

    // 1280x720p60 raster: 1650 x 750 total
    localparam int unsigned H_ACTIVE_720P = 1280;
    localparam int unsigned H_FP_720P     = 110;
    localparam int unsigned H_SYNC_720P   = 40;
    localparam int unsigned H_BP_720P     = 220;
    localparam int unsigned V_ACTIVE_720P = 720;
    localparam int unsigned V_FP_720P     = 5;
    localparam int unsigned V_SYNC_720P   = 5;
    localparam int unsigned V_BP_720P     = 20;

    // Coordinate / counter widths
    localparam int unsigned X_W = 11;
    localparam int unsigned Y_W = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vtg_state_e;

    // Total length of one axis (line or frame) in pixels or lines.
    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_axis_cnt.sv
// One raster axis counter: active, front porch, sync, back porch, then wrap.
module sync_axis_cnt
    import video_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = 8,
    parameter int unsigned FP     = 2,
    parameter int unsigned SYNC   = 2,
    parameter int unsigned BP     = 3,
    parameter int unsigned W      = 11
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         step_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o,
    output logic         active_o,
    output logic         sync_region_o
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [W-1:0] LAST_VAL   = W'(TOTAL - 1);
    localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
    // BP >= 1 keeps this below TOTAL, so it always fits in W bits
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] cnt_d, cnt_q;

    // Region decode straight from the current count
    always_comb begin
        last_o        = (cnt_q == LAST_VAL);
        active_o      = (cnt_q < ACTIVE_END);
        sync_region_o = (cnt_q >= SYNC_START) && (cnt_q < SYNC_END);
    end

    // Next count: clear wins, otherwise step and wrap at the end of the axis
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = last_o ? '0 : cnt_q + W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: syncs, blank, pixel coordinates, frame pulse and counter.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
    parameter int unsigned H_FP     = H_FP_720P,
    parameter int unsigned H_SYNC   = H_SYNC_720P,
    parameter int unsigned H_BP     = H_BP_720P,
    parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
    parameter int unsigned V_FP     = V_FP_720P,
    parameter int unsigned V_SYNC   = V_SYNC_720P,
    parameter int unsigned V_BP     = V_BP_720P,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           en_i,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           blank_o,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           frame_start_o,
    output logic [7:0]     frame_cnt_o,
    output logic           running_o
);

    vtg_state_e state_d, state_q;

    logic [X_W-1:0] h_cnt;
    logic [Y_W-1:0] v_cnt;
    logic           h_last, h_active, h_sync;
    logic           v_last, v_active, v_sync;
    logic           run, frame_end, pix_active;

    logic           hsync_d, hsync_q;
    logic           vsync_d, vsync_q;
    logic           blank_d, blank_q;
    logic [X_W-1:0] x_d, x_q;
    logic [Y_W-1:0] y_d, y_q;
    logic           frame_start_d, frame_start_q;
    logic [7:0]     frame_cnt_d, frame_cnt_q;
    logic           running_d, running_q;

    // Counters sit at zero in IDLE so the first RUN cycle is pixel (0,0)
    sync_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (X_W)
    ) u_h_cnt (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (!run),
        .step_i        (run),
        .cnt_o         (h_cnt),
        .last_o        (h_last),
        .active_o      (h_active),
        .sync_region_o (h_sync)
    );

    // Line counter advances on the last pixel of each line, so vsync edges land on h_cnt=0
    sync_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (Y_W)
    ) u_v_cnt (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (!run),
        .step_i        (run && h_last),
        .cnt_o         (v_cnt),
        .last_o        (v_last),
        .active_o      (v_active),
        .sync_region_o (v_sync)
    );

    // Run control: en is only honoured in IDLE or on the last pixel of a frame
    always_comb begin
        run       = (state_q == RUN);
        frame_end = run && h_last && v_last;
        state_d   = state_q;
        case (state_q)
            IDLE:    if (en_i) state_d = RUN;
            RUN:     if (frame_end && !en_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next-state, decoded from the live counters
    always_comb begin
        pix_active    = run && h_active && v_active;
        hsync_d       = (run && h_sync) ? HS_POL : ~HS_POL;
        vsync_d       = (run && v_sync) ? VS_POL : ~VS_POL;
        blank_d       = !pix_active;
        x_d           = pix_active ? h_cnt : '0;
        y_d           = pix_active ? v_cnt : '0;
        frame_start_d = run && (h_cnt == '0) && (v_cnt == '0);
        running_d     = run;
        frame_cnt_d   = frame_end ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    // FSM state and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            blank_q       <= 1'b1;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            running_q     <= running_d;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign blank_o       = blank_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign frame_start_o = frame_start_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign running_o     = running_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboarded bench: small active-high, small active-low and default 720p instances.
`timescale 1ns/1ps
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_s = 1'b0;
    logic en_n = 1'b0;
    logic en_h = 1'b0;

    always #5 clk = ~clk;

    // Small active-high instance
    logic s_hs, s_vs, s_blank, s_fs, s_run;
    logic [10:0] s_x;
    logic [9:0]  s_y;
    logic [7:0]  s_fcnt;
    // Small active-low instance
    logic n_hs, n_vs, n_blank, n_fs, n_run;
    logic [10:0] n_x;
    logic [9:0]  n_y;
    logic [7:0]  n_fcnt;
    // Default 720p instance
    logic h_hs, h_vs, h_blank, h_fs, h_run;
    logic [10:0] h_x;
    logic [9:0]  h_y;
    logic [7:0]  h_fcnt;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_small (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_s),
        .hsync_o(s_hs), .vsync_o(s_vs), .blank_o(s_blank), .x_o(s_x), .y_o(s_y),
        .frame_start_o(s_fs), .frame_cnt_o(s_fcnt), .running_o(s_run)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_neg (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_n),
        .hsync_o(n_hs), .vsync_o(n_vs), .blank_o(n_blank), .x_o(n_x), .y_o(n_y),
        .frame_start_o(n_fs), .frame_cnt_o(n_fcnt), .running_o(n_run)
    );

    video_timing_gen u_hd (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_h),
        .hsync_o(h_hs), .vsync_o(h_vs), .blank_o(h_blank), .x_o(h_x), .y_o(h_y),
        .frame_start_o(h_fs), .frame_cnt_o(h_fcnt), .running_o(h_run)
    );

    logic [33:0] obs_s, obs_n;
    assign obs_s = {s_hs, s_vs, s_blank, s_x, s_y, s_fs, s_fcnt, s_run};
    assign obs_n = {n_hs, n_vs, n_blank, n_x, n_y, n_fs, n_fcnt, n_run};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model of the small raster (15x8 total, active 8x4)
    typedef struct {
        bit run;
        int h;
        int v;
        int fcnt;
    } model_t;

    logic [33:0] sb_s[$];
    logic [33:0] sb_n[$];

    task automatic model_step(inout model_t m, input bit en, input bit pol,
                              output logic [33:0] e);
        bit act, hs, vs, fs;
        act = m.run && (m.h < 8) && (m.v < 4);
        hs  = (m.run && m.h >= 10 && m.h < 12) ? pol : ~pol;
        vs  = (m.run && m.v == 5) ? pol : ~pol;
        fs  = m.run && (m.h == 0) && (m.v == 0);
        e[33]    = hs;
        e[32]    = vs;
        e[31]    = !act;
        e[30:20] = act ? 11'(m.h) : 11'd0;
        e[19:10] = act ? 10'(m.v) : 10'd0;
        e[9]     = fs;
        e[0]     = m.run;
        if (!m.run) begin
            if (en) m.run = 1'b1;
        end else if (m.h == 14) begin
            m.h = 0;
            if (m.v == 7) begin
                m.v = 0;
                m.fcnt = (m.fcnt + 1) % 256;
                if (!en) m.run = 1'b0;
            end else begin
                m.v++;
            end
        end else begin
            m.h++;
        end
        e[8:1] = 8'(m.fcnt);
    endtask

    // Push expected outputs at each active edge
    initial begin
        model_t ms, mn;
        logic [33:0] e;
        ms = '{0, 0, 0, 0};
        mn = '{0, 0, 0, 0};
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                ms = '{0, 0, 0, 0};
                mn = '{0, 0, 0, 0};
            end else begin
                model_step(ms, en_s, 1'b1, e);
                sb_s.push_back(e);
                model_step(mn, en_n, 1'b0, e);
                sb_n.push_back(e);
            end
        end
    end

    // Compare on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_s.delete();
                sb_n.delete();
            end else begin
                if (sb_s.size() > 0) check_eq("sb_small", 64'(obs_s), 64'(sb_s.pop_front()));
                if (sb_n.size() > 0) check_eq("sb_neg", 64'(obs_n), 64'(sb_n.pop_front()));
            end
        end
    end

    function automatic logic sel_fs(input int sel);
        case (sel)
            0:       return s_fs;
            1:       return n_fs;
            default: return h_fs;
        endcase
    endfunction

    // Count falling edges until frame_start is seen (bounded)
    task automatic wait_fs(input int sel, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sel_fs(sel) && n < limit);
    endtask

    initial begin
        int n, act, hsc, vsc, first_hs, first_vs, post, xl;
        bit found;

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_small", 64'(obs_s), 64'({1'b0, 1'b0, 1'b1, 11'd0, 10'd0, 1'b0, 8'd0, 1'b0}));
        check_eq("rst_neg_syncs", 64'({n_hs, n_vs}), 64'(2'b11));
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check_eq("idle_no_en", 64'({s_run, s_blank}), 64'(2'b01));

        // Startup latency
        en_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("start_t1_fs", 64'({s_fs, s_run}), 64'(2'b00));
        @(posedge clk);
        @(negedge clk);
        check_eq("start_t2", 64'({s_fs, s_blank, s_x, s_y, s_run}),
                 64'({1'b1, 1'b0, 11'd0, 10'd0, 1'b1}));

        // One full small frame
        act = 0; hsc = 0; vsc = 0; first_hs = -1; first_vs = -1;
        for (int i = 0; i < 120; i++) begin
            if (i > 0) @(negedge clk);
            if (!s_blank) act++;
            if (s_hs) begin
                hsc++;
                if (first_hs < 0) first_hs = i;
            end
            if (s_vs) begin
                vsc++;
                if (first_vs < 0) first_vs = i;
            end
        end
        check_eq("frame_active", 64'(act), 64'(32));
        check_eq("frame_hsync", 64'(hsc), 64'(16));
        check_eq("first_hsync", 64'(first_hs), 64'(10));
        check_eq("frame_vsync", 64'(vsc), 64'(15));
        check_eq("first_vsync", 64'(first_vs), 64'(75));
        @(negedge clk);
        check_eq("fs_period", 64'({s_fs, s_fcnt}), 64'({1'b1, 8'd1}));

        // Stop mid-frame at pixel (3,2)
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (!s_blank && s_x == 11'd3 && s_y == 10'd2) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("stop_point_seen", 64'(found), 64'(1));
        #1 en_s = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (s_run && n < 300);
        check_eq("stop_cycles", 64'(n), 64'(87));
        check_eq("stop_idle", 64'({s_fcnt, s_blank, s_hs, s_vs}), 64'({8'd2, 1'b1, 1'b0, 1'b0}));
        repeat (20) @(negedge clk);
        check_eq("stay_idle", 64'({s_run, s_blank}), 64'(2'b01));

        // Restart
        @(posedge clk);
        #2 en_s = 1'b1;
        wait_fs(0, 10, n);
        check_eq("restart_latency", 64'(n), 64'(3));
        check_eq("restart_fcnt", 64'(s_fcnt), 64'(2));

        // Async reset while both syncs are active
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (s_hs && s_vs) found = 1'b1;
        end
        check_eq("sync_seen", 64'(found), 64'(1));
        #1 rst_n = 1'b0;
        en_s = 1'b0;
        #1;
        check_eq("async_rst", 64'(obs_s), 64'({1'b0, 1'b0, 1'b1, 11'd0, 10'd0, 1'b0, 8'd0, 1'b0}));
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("post_rst_idle", 64'({s_run, s_blank, s_fcnt}), 64'({1'b0, 1'b1, 8'd0}));

        // Default 720p: first line timing
        @(posedge clk);
        #2 en_h = 1'b1;
        wait_fs(2, 10, n);
        check_eq("hd_latency", 64'(n), 64'(3));
        check_eq("hd_origin", 64'({h_blank, h_x, h_y, h_fcnt}), 64'({1'b0, 11'd0, 10'd0, 8'd0}));
        act = 0; hsc = 0; first_hs = -1; post = 0; xl = -1;
        for (int i = 0; i < 1650; i++) begin
            if (i > 0) @(negedge clk);
            if (!h_blank) act++;
            if (i == 1279) xl = int'(h_x);
            if (h_hs) begin
                hsc++;
                if (first_hs < 0) first_hs = i;
            end else if (first_hs >= 0 && h_blank) begin
                post++;
            end
        end
        check_eq("hd_active", 64'(act), 64'(1280));
        check_eq("hd_last_x", 64'(xl), 64'(1279));
        check_eq("hd_first_hsync", 64'(first_hs), 64'(1390));
        check_eq("hd_hsync_width", 64'(hsc), 64'(40));
        check_eq("hd_back_porch", 64'(post), 64'(220));
        @(negedge clk);
        check_eq("hd_line1", 64'({h_blank, h_x, h_y}), 64'({1'b0, 11'd0, 10'd1}));

        // Active-low instance: 256 frames wrap the frame counter
        @(posedge clk);
        #2 en_n = 1'b1;
        wait_fs(1, 10, n);
        check_eq("neg_latency", 64'(n), 64'(3));
        check_eq("neg_idle_fcnt", 64'(n_fcnt), 64'(0));
        for (int k = 1; k <= 256; k++) begin
            wait_fs(1, 200, n);
            check_eq("neg_period", 64'(n), 64'(120));
            if (k == 255) check_eq("neg_fcnt_255", 64'(n_fcnt), 64'(255));
            if (k == 256) check_eq("neg_fcnt_wrap", 64'(n_fcnt), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
